// File: rtl/coffee_pkg.sv
// Shared state encodings and default timing constants for the brew sequencer.
package coffee_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StHeat     = 3'd1,
    StBrew     = 3'd2,
    StDispense = 3'd3,
    StDone     = 3'd4,
    StFault    = 3'd5
  } brew_state_e;

  localparam int unsigned DefaultDiv      = 50_000_000;
  localparam int unsigned DefaultHeatS    = 30;
  localparam int unsigned DefaultBrewS    = 60;
  localparam int unsigned DefaultDispenseS = 10;

  // True for the three timed phases of a brew cycle.
  function automatic logic is_busy(input brew_state_e s);
    return (s == StHeat) || (s == StBrew) || (s == StDispense);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV cycles; clr restarts the count.
module tick_prescaler
  import coffee_pkg::*;
#(
  parameter int unsigned DIV = DefaultDiv
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear on request, wrap at DIV-1, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/brew_sequencer.sv
// Coffee brew sequencer: IDLE -> HEAT -> BREW -> DISPENSE -> DONE with fault handling.
module brew_sequencer
  import coffee_pkg::*;
#(
  parameter int unsigned DIV        = DefaultDiv,
  parameter int unsigned HEAT_S     = DefaultHeatS,
  parameter int unsigned BREW_S     = DefaultBrewS,
  parameter int unsigned DISPENSE_S = DefaultDispenseS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cancel,
  input  logic       water_ok,
  output logic [2:0] state,
  output logic       busy,
  output logic       done,
  output logic [7:3] led
);

  localparam logic [7:0] HeatLast     = 8'(HEAT_S - 1);
  localparam logic [7:0] BrewLast     = 8'(BREW_S - 1);
  localparam logic [7:0] DispenseLast = 8'(DISPENSE_S - 1);

  brew_state_e state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic        hb_q, hb_d;
  logic        tick;
  logic        clr;
  logic        busy_q;
  logic [7:0]  phase_last;
  logic        phase_end;

  // Any state change restarts both the prescaler and the phase counter, so each
  // phase lasts exactly PHASE_S*DIV cycles.
  assign clr = (state_d != state_q);

  tick_prescaler #(
    .DIV(DIV)
  ) u_tick_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  assign busy_q = is_busy(state_q);

  // Select the terminal phase count for the current phase.
  always_comb begin
    phase_last = 8'd0;
    case (state_q)
      StHeat:     phase_last = HeatLast;
      StBrew:     phase_last = BrewLast;
      StDispense: phase_last = DispenseLast;
      default:    phase_last = 8'd0;
    endcase
  end

  assign phase_end = tick && (phase_q == phase_last);

  // Next-state decode; cancel beats water loss, which beats phase end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start && !cancel) begin
          state_d = water_ok ? StHeat : StFault;
        end
      end
      StHeat: begin
        if (cancel)         state_d = StIdle;
        else if (!water_ok) state_d = StFault;
        else if (phase_end) state_d = StBrew;
      end
      StBrew: begin
        if (cancel)         state_d = StIdle;
        else if (!water_ok) state_d = StFault;
        else if (phase_end) state_d = StDispense;
      end
      StDispense: begin
        if (cancel)         state_d = StIdle;
        else if (phase_end) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      StFault: begin
        if (cancel) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Phase counter and heartbeat next values.
  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = 8'd0;
    end else if (tick && busy_q) begin
      phase_d = phase_q + 8'd1;
    end
    // Heartbeat parity survives phase-to-phase moves and drops when leaving busy.
    hb_d = is_busy(state_d) ? (hb_q ^ (tick && busy_q)) : 1'b0;
  end

  // FSM, phase counter and heartbeat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= 8'd0;
      hb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hb_q    <= hb_d;
    end
  end

  assign state  = state_q;
  assign busy   = busy_q;
  assign done   = (state_q == StDone);
  // The tick cycle itself already shows the toggled value; both terms are registered.
  assign led[3] = hb_q ^ (tick && busy_q);
  assign led[4] = (state_q == StHeat);
  assign led[5] = (state_q == StBrew);
  assign led[6] = (state_q == StDispense);
  assign led[7] = (state_q == StFault);

endmodule

// File: tb/tb_brew_sequencer.sv
// Scoreboard bench for brew_sequencer with short timing parameters.
module tb_brew_sequencer;
  import coffee_pkg::*;

  localparam int unsigned Div   = 4;
  localparam int unsigned HeatS = 2;
  localparam int unsigned BrewS = 3;
  localparam int unsigned DispS = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       water_ok = 1'b1;
  logic [2:0] state;
  logic       busy;
  logic       done;
  logic [7:3] led;

  brew_sequencer #(
    .DIV       (Div),
    .HEAT_S    (HeatS),
    .BREW_S    (BrewS),
    .DISPENSE_S(DispS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cancel  (cancel),
    .water_ok(water_ok),
    .state   (state),
    .busy    (busy),
    .done    (done),
    .led     (led)
  );

  always #5 clk = ~clk;

  // Posedge count; an expectation for cycle c is checked at the negedge after posedge c.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  st;
    logic        busy;
    logic        done;
    logic [7:3]  led;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic push(input int unsigned c, input logic [2:0] st, input logic [7:3] ld,
                      input string nm);
    exp_t e;
    e.cyc  = c;
    e.st   = st;
    e.busy = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
    e.done = (st == 3'd4);
    e.led  = ld;
    e.nm   = nm;
    sb_q.push_back(e);
  endtask

  // Hand-derived nominal run, k counted from the start-sampling edge.
  task automatic nom(input int k, output logic [2:0] st, output logic [7:3] ld);
    logic hb;
    hb = (k >= 4 && k <= 7) || (k >= 12 && k <= 15) || (k >= 20 && k <= 23);
    if (k <= 8) begin
      st = 3'd1; ld = {4'b0001, hb};
    end else if (k <= 20) begin
      st = 3'd2; ld = {4'b0010, hb};
    end else if (k <= 24) begin
      st = 3'd3; ld = {4'b0100, hb};
    end else if (k == 25) begin
      st = 3'd4; ld = 5'b00000;
    end else begin
      st = 3'd0; ld = 5'b00000;
    end
  endtask

  task automatic push_nom(input int unsigned p, input int k0, input int k1, input string nm);
    logic [2:0] st;
    logic [7:3] ld;
    for (int k = k0; k <= k1; k++) begin
      nom(k, st, ld);
      push(p + k - 1, st, ld, nm);
    end
  endtask

  task automatic goto(input int unsigned c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Raises start at a negedge; p is the posedge that samples it (edge 0).
  task automatic begin_start(output int unsigned p);
    @(negedge clk);
    start = 1'b1;
    p = cyc + 1;
  endtask

  // Monitor: pop every expectation due this cycle and compare.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", mon_e.nm, mon_e.cyc,
                 cyc);
      end else if ({state, busy, done, led} !== {mon_e.st, mon_e.busy, mon_e.done, mon_e.led}) begin
        errors++;
        $display("FAIL %s @cyc %0d: got state=%0d busy=%b done=%b led=%b, want state=%0d busy=%b done=%b led=%b",
                 mon_e.nm, cyc, state, busy, done, led, mon_e.st, mon_e.busy, mon_e.done,
                 mon_e.led);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p;

    // Reset hold and idle after release.
    push(1, StIdle, 5'b00000, "reset_hold");
    push(2, StIdle, 5'b00000, "reset_hold");
    goto(2);
    rst_n = 1'b1;
    push(3, StIdle, 5'b00000, "idle_after_reset");
    push(4, StIdle, 5'b00000, "idle_after_reset");
    goto(5);

    // Nominal cycle.
    begin_start(p);
    push_nom(p, 1, 26, "nominal");
    goto(p);
    start = 1'b0;
    goto(p + 28);

    // start with cancel in IDLE stays IDLE.
    @(negedge clk);
    start  = 1'b1;
    cancel = 1'b1;
    p = cyc + 1;
    for (int i = 0; i < 3; i++) push(p + i, StIdle, 5'b00000, "start_with_cancel");
    goto(p + 2);
    start  = 1'b0;
    cancel = 1'b0;
    goto(p + 4);

    // Dry start goes to FAULT and holds until cancel.
    @(negedge clk);
    water_ok = 1'b0;
    begin_start(p);
    for (int k = 1; k <= 10; k++) push(p + k - 1, StFault, 5'b10000, "dry_fault");
    push(p + 10, StIdle, 5'b00000, "dry_cancel");
    goto(p);
    start    = 1'b0;
    water_ok = 1'b1;
    goto(p + 9);
    cancel = 1'b1;
    goto(p + 10);
    cancel = 1'b0;
    goto(p + 12);

    // Water loss during BREW.
    begin_start(p);
    push_nom(p, 1, 12, "water_pre");
    for (int k = 13; k <= 21; k++) push(p + k - 1, StFault, 5'b10000, "water_fault");
    push(p + 21, StIdle, 5'b00000, "water_cancel");
    goto(p);
    start = 1'b0;
    goto(p + 11);
    water_ok = 1'b0;
    goto(p + 20);
    water_ok = 1'b1;
    cancel   = 1'b1;
    goto(p + 21);
    cancel = 1'b0;
    goto(p + 23);

    // Cancel during HEAT, then a fresh full run.
    begin_start(p);
    push_nom(p, 1, 5, "cancel_pre");
    push(p + 5, StIdle, 5'b00000, "cancel_idle");
    push(p + 6, StIdle, 5'b00000, "cancel_idle");
    goto(p);
    start = 1'b0;
    goto(p + 4);
    cancel = 1'b1;
    goto(p + 5);
    cancel = 1'b0;
    goto(p + 7);
    begin_start(p);
    push_nom(p, 1, 26, "rerun");
    goto(p);
    start = 1'b0;
    goto(p + 27);

    // Asynchronous reset mid-BREW.
    begin_start(p);
    push_nom(p, 1, 14, "reset_pre");
    push(p + 14, StIdle, 5'b00000, "reset_async");
    push(p + 15, StIdle, 5'b00000, "reset_async");
    for (int k = 18; k <= 23; k++) push(p + k - 1, StIdle, 5'b00000, "reset_stay_idle");
    goto(p);
    start = 1'b0;
    goto(p + 13);
    @(posedge clk);
    #1 rst_n = 1'b0;
    goto(p + 16);
    rst_n = 1'b1;
    goto(p + 24);

    // start held through DONE restarts one cycle after IDLE.
    begin_start(p);
    push_nom(p, 1, 26, "held");
    push(p + 26, StHeat, 5'b00010, "held_restart");
    push(p + 27, StIdle, 5'b00000, "held_cancel");
    goto(p + 26);
    start  = 1'b0;
    cancel = 1'b1;
    goto(p + 27);
    cancel = 1'b0;
    goto(p + 30);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending: %0d expectations never checked, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 Parameter DIV, default 50_000_000, clk cycles per one-second tick; legal range 2 or more.
REQ-002 Parameter HEAT_S, default 30, heat phase length in ticks; legal range 1 to 255.
REQ-003 Parameter BREW_S, default 60, brew phase length in ticks; legal range 1 to 255.
REQ-004 Parameter DISPENSE_S, default 10, dispense phase length in ticks; legal range 1 to 255.
REQ-005 Port clk  input  1  system clock; all flops rising-edge.
REQ-006 Port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-007 Port start  input  1  level; requests a brew cycle; sampled only in IDLE.
REQ-008 Port cancel  input  1  level; aborts any active cycle and clears FAULT.
REQ-009 Port water_ok  input  1  level; 1 = reservoir sufficient.
REQ-010 Port state  output  3  current FSM state encoding.
REQ-011 Port busy  output  1  high in HEAT, BREW and DISPENSE.
REQ-012 Port done  output  1  one-cycle pulse on cycle completion.
REQ-013 Port led  output  5 (bits [7:3])  panel LEDs; led[3] heartbeat, led[4] HEAT, led[5] BREW, led[6] DISPENSE, led[7] FAULT.

Function
REQ-014 State encodings SHALL be IDLE=0, HEAT=1, BREW=2, DISPENSE=3, DONE=4, FAULT=5; codes 6 and 7 SHALL go to IDLE on the next cycle.
REQ-015 Prescaler SHALL count 0 to DIV-1 and wrap; tick SHALL be high for one cycle when the count equals DIV-1.
REQ-016 Prescaler and phase counter SHALL clear to 0 on the cycle any state is entered, so every phase lasts exactly PHASE_S*DIV cycles.
REQ-017 Phase counter (8 bits) SHALL increment on tick; the phase SHALL end on the tick where the count equals PHASE_S-1.
REQ-018 IDLE: start=1 and water_ok=1 SHALL give HEAT next cycle; start=1 and water_ok=0 SHALL give FAULT next cycle; otherwise stay.
REQ-019 At phase end: HEAT SHALL go to BREW, BREW SHALL go to DISPENSE, and DISPENSE SHALL go to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-021 In HEAT or BREW, water_ok=0 SHALL give FAULT next cycle; water_ok SHALL be ignored in DISPENSE.
REQ-022 FAULT SHALL hold until cancel=1, then go to IDLE.
REQ-023 Priority SHALL be cancel first, then water_ok fault, then phase end.
REQ-024 In IDLE, cancel SHALL have no effect, and start=1 with cancel=1 SHALL stay in IDLE.
REQ-025 start held high through DONE SHALL begin a new cycle from IDLE, one cycle after returning to IDLE.
REQ-026 led[3] SHALL toggle on each tick while busy=1 and SHALL be 0 when busy=0.
REQ-027 led[6:4] SHALL be one-hot with the phase; led[7] SHALL equal (state==FAULT).
REQ-028 All outputs SHALL be registered or decoded directly from registered state, with no combinational path from inputs to outputs.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, prescaler=0, phase counter=0, busy=0, done=0 and led=5'b00000.
REQ-030 Reset asserted mid-phase SHALL abandon the cycle; after release the block SHALL stay in IDLE until a new start.
REQ-031 Reset deassertion is synchronized externally; the block SHALL need no internal reset synchronizer.

Structure
REQ-032 Package coffee_pkg SHALL hold the state encodings and the default DIV, HEAT_S, BREW_S and DISPENSE_S constants.
REQ-033 Sub-module tick_prescaler (inputs clk, rst_n, clr; output tick; parameter DIV) SHALL implement REQ-015 and REQ-016.
REQ-034 The FSM, phase counter and LED decode SHALL reside in brew_sequencer.

Verification (DIV=4, HEAT_S=2, BREW_S=3, DISPENSE_S=1; start sampled at edge 0)
REQ-035 Nominal: one-cycle start with water_ok=1 -> HEAT at edges 1-8, BREW at 9-20, DISPENSE at 21-24, done=1 only at edge 25, IDLE at 26.
REQ-036 Dry start: start=1 with water_ok=0 -> FAULT at edge 1 and led=5'b10000 held; cancel at edge 10 -> IDLE at edge 11.
REQ-037 Water loss: water_ok drops at edge 12 (in BREW) -> FAULT at edge 13, busy=0, and no done pulse.
REQ-038 Cancel: cancel at edge 5 (in HEAT) -> IDLE at edge 6 and led=0; a fresh start runs the full 25-cycle sequence again.
REQ-039 Reset: rst_n low at edge 15 -> all outputs 0 within that cycle; after release, stays IDLE with start=0.
REQ-040 Heartbeat: led[3] toggles at edges 4, 8, 12, 16, 20 and 24 of the nominal run, and is 0 from edge 25.
